// File: rtl/dram_port_arbiter_pkg.sv
// Shared encodings for the DRAM port arbiter: access ctrl codes, FSM states, port ids.
package dram_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned WDOG_W = 13;

    // ctrl[1:0] is the access size, ctrl[2] requests an unsigned (zero-extended) load
    localparam logic [CTRL_W-1:0] CTRL_LB  = 3'b000;
    localparam logic [CTRL_W-1:0] CTRL_LH  = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_LW  = 3'b010;
    localparam logic [CTRL_W-1:0] CTRL_LBU = 3'b100;
    localparam logic [CTRL_W-1:0] CTRL_LHU = 3'b101;
    localparam logic [CTRL_W-1:0] CTRL_SB  = 3'b000;
    localparam logic [CTRL_W-1:0] CTRL_SH  = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_SW  = 3'b010;
    localparam int unsigned       CTRL_U   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } arb_port_e;

    // Unsigned offset compare also rejects addresses below the base (they wrap high)
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/dram_port_arbiter.sv
// Merges the instruction-fetch and data ports onto the single DRAM controller interface,
// with round-robin arbitration, address-window check and a busy watchdog.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter logic [31:0] DRAM_BASE = 32'h8000_0000,
    parameter logic [31:0] DRAM_SIZE = 32'h0080_0000,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic              o_if_ack,
    output logic [31:0]       o_if_data,
    input  logic              i_d_rd,
    input  logic              i_d_wr,
    input  logic [31:0]       i_d_addr,
    input  logic [31:0]       i_d_wdata,
    input  logic [2:0]        i_d_ctrl,
    output logic              o_d_ack,
    output logic [31:0]       o_d_rdata,
    output logic              o_d_err,
    output logic              o_mem_rd_en,
    output logic              o_mem_wr_en,
    output logic [31:0]       o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [2:0]        o_mem_ctrl,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_busy,
    input  logic              i_init_done,
    output logic              o_timeout
);

    arb_state_e        state_q, state_d;
    arb_port_e         last_q, last_d;
    arb_port_e         port_q, port_d;
    logic              wr_q, wr_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic              rd_en_d, wr_en_d, if_ack_d, d_ack_d, d_err_d, timeout_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, if_data_d, d_rdata_d;
    logic [CTRL_W-1:0] ctrl_d;

    logic              d_req, sel_fetch, req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic              fin, fin_err;
    arb_port_e         fin_port;
    logic              fin_wr;

    assign d_req = i_d_rd | i_d_wr;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        port_d    = port_q;
        wr_d      = wr_q;
        wdog_d    = wdog_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        timeout_d = o_timeout;
        addr_d    = o_mem_addr;
        wdata_d   = o_mem_wdata;
        ctrl_d    = o_mem_ctrl;
        if_data_d = o_if_data;
        d_rdata_d = o_d_rdata;
        sel_fetch = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_port  = port_q;
        fin_wr    = wr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_init_done && !i_mem_busy && (i_if_req || d_req)) begin
                    sel_fetch = i_if_req && (!d_req || last_q == PORT_DATA);
                    req_wr    = !sel_fetch && i_d_wr && !i_d_rd;
                    req_addr  = sel_fetch ? i_if_addr : i_d_addr;
                    port_d    = sel_fetch ? PORT_FETCH : PORT_DATA;
                    wr_d      = req_wr;
                    if (in_window(req_addr, DRAM_BASE, DRAM_SIZE)) begin
                        state_d = ST_ISSUE;
                        rd_en_d = !req_wr;
                        wr_en_d = req_wr;
                        addr_d  = req_addr;
                        wdata_d = sel_fetch ? '0 : i_d_wdata;
                        ctrl_d  = sel_fetch ? CTRL_LW : i_d_ctrl;
                    end else begin
                        fin      = 1'b1;
                        fin_err  = 1'b1;
                        fin_port = port_d;
                        fin_wr   = req_wr;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wdog_d  = '0;
            end
            ST_WAIT: begin
                // wdog_q == 0 marks the first WAIT cycle, where busy is not yet meaningful
                if (wdog_q != '0 && !i_mem_busy) begin
                    fin = 1'b1;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion: registered ack lands in the DONE cycle
        if (fin) begin
            state_d = ST_DONE;
            last_d  = fin_port;
            if (fin_port == PORT_FETCH) begin
                if_ack_d  = 1'b1;
                if_data_d = fin_err ? '0 : i_mem_rdata;
            end else begin
                d_ack_d = 1'b1;
                d_err_d = fin_err;
                if (!fin_err && !fin_wr) begin
                    d_rdata_d = i_mem_rdata;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT_DATA;
            port_q      <= PORT_FETCH;
            wr_q        <= 1'b0;
            wdog_q      <= '0;
            o_mem_rd_en <= 1'b0;
            o_mem_wr_en <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_ctrl  <= '0;
            o_if_ack    <= 1'b0;
            o_if_data   <= '0;
            o_d_ack     <= 1'b0;
            o_d_rdata   <= '0;
            o_d_err     <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            wr_q        <= wr_d;
            wdog_q      <= wdog_d;
            o_mem_rd_en <= rd_en_d;
            o_mem_wr_en <= wr_en_d;
            o_mem_addr  <= addr_d;
            o_mem_wdata <= wdata_d;
            o_mem_ctrl  <= ctrl_d;
            o_if_ack    <= if_ack_d;
            o_if_data   <= if_data_d;
            o_d_ack     <= d_ack_d;
            o_d_rdata   <= d_rdata_d;
            o_d_err     <= d_err_d;
            o_timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter with a small behavioural DRAM controller.
module tb_dram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        o_if_ack;
    logic [31:0] o_if_data;
    logic        i_d_rd = 1'b0;
    logic        i_d_wr = 1'b0;
    logic [31:0] i_d_addr = '0;
    logic [31:0] i_d_wdata = '0;
    logic [2:0]  i_d_ctrl = '0;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;
    logic        o_d_err;
    logic        o_mem_rd_en;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [2:0]  o_mem_ctrl;
    logic [31:0] i_mem_rdata = '0;
    logic        i_mem_busy;
    logic        i_init_done = 1'b0;
    logic        o_timeout;

    dram_port_arbiter dut (
        .clk         (clk),
        .rst_x       (rst_x),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_ack    (o_if_ack),
        .o_if_data   (o_if_data),
        .i_d_rd      (i_d_rd),
        .i_d_wr      (i_d_wr),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .i_d_ctrl    (i_d_ctrl),
        .o_d_ack     (o_d_ack),
        .o_d_rdata   (o_d_rdata),
        .o_d_err     (o_d_err),
        .o_mem_rd_en (o_mem_rd_en),
        .o_mem_wr_en (o_mem_wr_en),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_ctrl  (o_mem_ctrl),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_busy  (i_mem_busy),
        .i_init_done (i_init_done),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises the cycle after an enable and stays up busy_len cycles
    int   busy_len = 5;
    bit   hang_arm = 1'b0;
    int   busy_cnt = 0;
    logic hang_q = 1'b0;
    assign i_mem_busy = (busy_cnt != 0) || hang_q;

    always @(posedge clk) begin
        if (o_mem_rd_en || o_mem_wr_en) begin
            busy_cnt <= busy_len;
            if (hang_arm) hang_q <= 1'b1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (!hang_arm) hang_q <= 1'b0;
    end

    // Bus monitor: enable-cycle counts and a log of issued addresses
    int          rd_cnt = 0, wr_cnt = 0, if_ack_cnt = 0, d_ack_cnt = 0, log_n = 0;
    logic [31:0] log_addr [16];
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [2:0]  last_ctrl = '0;

    always @(posedge clk) begin
        if (o_mem_rd_en) rd_cnt++;
        if (o_mem_wr_en) wr_cnt++;
        if (o_if_ack) if_ack_cnt++;
        if (o_d_ack) d_ack_cnt++;
        if (o_mem_rd_en || o_mem_wr_en) begin
            last_addr  = o_mem_addr;
            last_wdata = o_mem_wdata;
            last_ctrl  = o_mem_ctrl;
            if (log_n < 16) log_addr[log_n] = o_mem_addr;
            log_n++;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the chosen port's ack; n = posedges taken from the call
    task automatic wait_ack(input string tag, input bit data_port, input int max, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            @(posedge clk);
            #1;
            n++;
            seen = data_port ? o_d_ack : o_if_ack;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, rd0, wr0, acks, rounds, f_done, d_done;

        // Reset values
        #3;
        check("rst_if_ack", 32'(o_if_ack), 32'd0);
        check("rst_mem_rd_en", 32'(o_mem_rd_en), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        cycles(2);
        rst_x = 1'b1;
        i_init_done = 1'b1;
        cycles(2);

        // Contention twice: fetch, data, fetch, data
        busy_len = 2;
        i_mem_rdata = 32'hCAFE_0001;
        i_if_addr = 32'h8000_0100;
        i_d_addr  = 32'h8000_0200;
        i_d_ctrl  = 3'b010;
        rounds = 0;
        n = 0;
        i_if_req = 1'b1;
        i_d_rd   = 1'b1;
        f_done = 0;
        d_done = 0;
        while (rounds < 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (o_if_ack) begin i_if_req = 1'b0; f_done = 1; end
            if (o_d_ack) begin i_d_rd = 1'b0; d_done = 1; end
            if (f_done == 1 && d_done == 1) begin
                rounds++;
                f_done = 0;
                d_done = 0;
                if (rounds < 2) begin i_if_req = 1'b1; i_d_rd = 1'b1; end
            end
        end
        check("rr_rounds", 32'(rounds), 32'd2);
        check("rr_grant0", log_addr[0], 32'h8000_0100);
        check("rr_grant1", log_addr[1], 32'h8000_0200);
        check("rr_grant2", log_addr[2], 32'h8000_0100);
        check("rr_grant3", log_addr[3], 32'h8000_0200);
        check("rr_d_rdata", o_d_rdata, 32'hCAFE_0001);
        cycles(2);

        // Fetch with 5 busy cycles: ack 8 edges after the request is driven
        busy_len = 5;
        i_mem_rdata = 32'h1234_5678;
        rd0 = rd_cnt;
        i_if_addr = 32'h8000_0010;
        i_if_req = 1'b1;
        wait_ack("fetch_ack", 1'b0, 50, n);
        i_if_req = 1'b0;
        check("fetch_latency", 32'(n), 32'd8);
        check("fetch_data", o_if_data, 32'h1234_5678);
        check("fetch_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check("fetch_ctrl", 32'(last_ctrl), 32'(3'b010));
        cycles(2);

        // Unaligned SW
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        i_d_addr  = 32'h8000_0003;
        i_d_wdata = 32'hAABB_CCDD;
        i_d_ctrl  = 3'b010;
        i_d_wr = 1'b1;
        wait_ack("sw_ack", 1'b1, 50, n);
        i_d_wr = 1'b0;
        check("sw_err", 32'(o_d_err), 32'd0);
        check("sw_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        check("sw_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("sw_addr", last_addr, 32'h8000_0003);
        check("sw_wdata", last_wdata, 32'hAABB_CCDD);
        check("sw_ctrl", 32'(last_ctrl), 32'(3'b010));
        check("sw_rdata_kept", o_d_rdata, 32'hCAFE_0001);
        cycles(2);

        // Out-of-window LB: immediate error, no DRAM access
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        i_d_addr = 32'h0000_1000;
        i_d_ctrl = 3'b000;
        i_d_rd = 1'b1;
        wait_ack("oow_ack", 1'b1, 3, n);
        i_d_rd = 1'b0;
        check("oow_latency", 32'(n), 32'd1);
        check("oow_err", 32'(o_d_err), 32'd1);
        cycles(3);
        check("oow_err_clears", 32'(o_d_err), 32'd0);
        check("oow_no_access", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

        // Window edges: one past the end is rejected, last byte is accepted
        i_d_addr = 32'h8080_0000;
        i_d_rd = 1'b1;
        wait_ack("edge_hi_ack", 1'b1, 3, n);
        i_d_rd = 1'b0;
        check("edge_hi_err", 32'(o_d_err), 32'd1);
        check("edge_hi_no_rd", 32'(rd_cnt - rd0), 32'd0);
        cycles(2);
        busy_len = 1;
        i_mem_rdata = 32'h0000_00FF;
        i_d_addr = 32'h807F_FFFF;
        i_d_ctrl = 3'b100;
        i_d_rd = 1'b1;
        wait_ack("edge_lo_ack", 1'b1, 50, n);
        i_d_rd = 1'b0;
        check("edge_lo_err", 32'(o_d_err), 32'd0);
        check("edge_lo_rd", 32'(rd_cnt - rd0), 32'd1);
        check("edge_lo_rdata", o_d_rdata, 32'h0000_00FF);
        check("edge_lo_ctrl", 32'(last_ctrl), 32'(3'b100));
        cycles(2);

        // Watchdog: controller never drops busy
        hang_arm = 1'b1;
        i_d_addr = 32'h8000_0040;
        i_d_ctrl = 3'b010;
        i_d_rd = 1'b1;
        acks = d_ack_cnt;
        cycles(4000);
        check("wdog_not_early", 32'(o_timeout), 32'd0);
        check("wdog_no_ack_early", 32'(d_ack_cnt - acks), 32'd0);
        wait_ack("wdog_ack", 1'b1, 300, n);
        i_d_rd = 1'b0;
        check("wdog_err", 32'(o_d_err), 32'd1);
        check("wdog_timeout", 32'(o_timeout), 32'd1);
        check("wdog_rdata_kept", o_d_rdata, 32'h0000_00FF);
        hang_arm = 1'b0;
        cycles(2);

        busy_len = 2;
        i_mem_rdata = 32'h0BAD_F00D;
        i_if_addr = 32'h8000_0020;
        i_if_req = 1'b1;
        wait_ack("post_wdog_ack", 1'b0, 50, n);
        i_if_req = 1'b0;
        check("post_wdog_data", o_if_data, 32'h0BAD_F00D);
        check("timeout_sticky", 32'(o_timeout), 32'd1);
        cycles(2);

        // Asynchronous reset in WAIT aborts the fetch without an ack
        busy_len = 30;
        rd0 = rd_cnt;
        i_if_addr = 32'h8000_0080;
        i_if_req = 1'b1;
        cycles(4);
        check("abort_issued", 32'(rd_cnt - rd0), 32'd1);
        acks = if_ack_cnt;
        #2;
        rst_x = 1'b0;
        #1;
        check("abort_addr_zero", o_mem_addr, 32'd0);
        check("abort_timeout_zero", 32'(o_timeout), 32'd0);
        check("abort_data_zero", o_if_data, 32'd0);
        i_if_req = 1'b0;
        cycles(2);
        rst_x = 1'b1;
        cycles(40);
        check("abort_no_ack", 32'(if_ack_cnt - acks), 32'd0);

        // Controller not calibrated: requests stay pending, nothing issued
        i_init_done = 1'b0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        i_if_addr = 32'h8000_0000;
        i_d_addr  = 32'h8000_0004;
        i_if_req = 1'b1;
        i_d_wr = 1'b1;
        cycles(20);
        check("nocal_no_access", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        busy_len = 1;
        i_init_done = 1'b1;
        wait_ack("cal_fetch_ack", 1'b0, 50, n);
        i_if_req = 1'b0;
        i_d_wr = 1'b0;
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
